// File: rtl/tnn_share_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tnn_share_sched: round-robin sharing of one combinational TNN classifier   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tnn_share_sched #(
  parameter int N      = 16,
  parameter int B      = 4,
  parameter int C      = 10,
  parameter int R      = 4,
  parameter int SETTLE = 2,
  localparam int SW    = N * B,
  localparam int KW    = (C > 1) ? $clog2(C) : 1,
  localparam int IW    = (R > 1) ? $clog2(R) : 1,
  localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [R-1:0]      req_valid,
  input  logic [R*SW-1:0]   req_data,
  output logic [R-1:0]      req_ready,
  output logic [SW-1:0]     tnn_inp,
  input  logic [KW-1:0]     tnn_klass,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [KW-1:0]     res_klass,
  output logic [IW-1:0]     res_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_OUT    = 2'd2
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [IW-1:0]   last_grant;
  logic [CW-1:0]   count;
  logic            grant_found;
  logic [IW-1:0]   grant_idx;
  logic [SW-1:0]   grant_sample;
  logic            transfer;
  int              scan_idx;

  // Rotating priority scan starting one past the most recent grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 0; k < R; k++) begin
      scan_idx = (int'(last_grant) + 1 + k) % R;
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(scan_idx);
      end
    end
  end

  // Grants only leave the block while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_found && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign grant_sample = req_data[grant_idx*SW +: SW];
  assign transfer     = |(req_valid & req_ready);
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (transfer)    state_d = S_SETTLE;
      S_SETTLE: if (count == '0) state_d = S_OUT;
      S_OUT:    if (res_ready)   state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tnn_inp    <= '0;
      res_id     <= '0;
      res_klass  <= '0;
      res_valid  <= 1'b0;
      count      <= '0;
      last_grant <= IW'(R - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (transfer) begin
            tnn_inp    <= grant_sample;
            res_id     <= grant_idx;
            last_grant <= grant_idx;
            count      <= CW'(SETTLE - 1);
          end
        end
        S_SETTLE: begin
          // The classifier output is sampled only after tnn_inp has been stable SETTLE cycles.
          if (count == '0) begin
            res_klass <= tnn_klass;
            res_valid <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
          end
        end
        default: begin
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tnn_share_sched.sv
`default_nettype none
// Directed self-checking bench for tnn_share_sched (SETTLE=2 and SETTLE=1 builds).
module tb_tnn_share_sched;

  localparam logic [63:0] S_SINGLE = 64'h0e4f7c572260b0f1;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready;
  logic [255:0] req_data;
  logic [63:0]  tnn_inp;
  logic [3:0]   tnn_klass;
  logic         res_valid, res_ready, busy;
  logic [3:0]   res_klass;
  logic [1:0]   res_id;

  logic [3:0]   req_valid1, req_ready1;
  logic [255:0] req_data1;
  logic [63:0]  tnn_inp1;
  logic [3:0]   tnn_klass1;
  logic         res_valid1, res_ready1, busy1;
  logic [3:0]   res_klass1;
  logic [1:0]   res_id1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign tnn_klass  = tnn_inp[3:0] % 4'd10;
  assign tnn_klass1 = tnn_inp1[3:0] % 4'd10;

  tnn_share_sched #(.N(16), .B(4), .C(10), .R(4), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tnn_inp(tnn_inp), .tnn_klass(tnn_klass),
    .res_valid(res_valid), .res_ready(res_ready), .res_klass(res_klass),
    .res_id(res_id), .busy(busy)
  );

  tnn_share_sched #(.N(16), .B(4), .C(10), .R(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_data(req_data1),
    .req_ready(req_ready1), .tnn_inp(tnn_inp1), .tnn_klass(tnn_klass1),
    .res_valid(res_valid1), .res_ready(res_ready1), .res_klass(res_klass1),
    .res_id(res_id1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_data = '0; res_ready = 1'b0;
    req_valid1 = '0; req_data1 = '0; res_ready1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111; req_data = '1; res_ready = 1'b1;
    req_valid1 = '0; req_data1 = '0; res_ready1 = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++; if (tnn_inp !== 64'h0) begin failures++; $display("FAIL reset_tnn_inp got=%h exp=0", tnn_inp); end
    checks++; if (res_klass !== 4'h0 || res_id !== 2'd0) begin failures++; $display("FAIL reset_res got=%h/%h exp=0/0", res_id, res_klass); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_prio got=%b exp=0001", req_ready); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001; req_data[63:0] = S_SINGLE;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (tnn_inp !== S_SINGLE) begin failures++; $display("FAIL single_tnn_inp got=%h exp=%h", tnn_inp, S_SINGLE); end
    checks++; if (busy !== 1'b1 || res_valid !== 1'b0) begin failures++; $display("FAIL single_c1 busy/valid got=%b/%b exp=1/0", busy, res_valid); end
    tick();
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_c2_valid got=%b exp=0", res_valid); end
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL single_c3_valid got=%b exp=1", res_valid); end
    checks++; if (res_klass !== 4'd1 || res_id !== 2'd0) begin failures++; $display("FAIL single_result got=%0d/%0d exp=0/1", res_id, res_klass); end
    tick();
    res_ready = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL single_c4 busy/valid got=%b/%b exp=0/0", busy, res_valid); end
    checks++; if (tnn_inp !== S_SINGLE) begin failures++; $display("FAIL single_inp_kept got=%h exp=%h", tnn_inp, S_SINGLE); end
  endtask

  task automatic test_round_robin();
    int ng, nr;
    int gcyc[5];
    logic [3:0] gval[5];
    logic [1:0] rid[4];
    logic [3:0] rk[4];
    logic [3:0] exp_k[4];
    exp_k = '{4'd5, 4'd0, 4'd0, 4'd0};
    ng = 0; nr = 0;
    do_reset();
    req_data[0*64 +: 64] = 64'h8f4d96400498fe6f;
    req_data[1*64 +: 64] = 64'h095bceffcc884430;
    req_data[2*64 +: 64] = 64'h0f1f1b37e5f7c4b0;
    req_data[3*64 +: 64] = 64'h0b8dffddaa665380;
    req_valid = 4'b1111; res_ready = 1'b1;
    for (int cyc = 0; cyc < 17; cyc++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000) begin
        if (ng < 5) begin gcyc[ng] = cyc; gval[ng] = req_ready; end
        ng++;
      end
      if (res_valid === 1'b1) begin
        if (nr < 4) begin rid[nr] = res_id; rk[nr] = res_klass; end
        nr++;
      end
      tick();
    end
    checks++; if (ng !== 5) begin failures++; $display("FAIL rr_grant_count got=%0d exp=5", ng); end
    checks++; if (nr !== 4) begin failures++; $display("FAIL rr_result_count got=%0d exp=4", nr); end
    for (int i = 0; i < 5 && i < ng; i++) begin
      checks++;
      if (gval[i] !== (4'b0001 << (i % 4)) || gcyc[i] !== 4 * i) begin
        failures++;
        $display("FAIL rr_grant%0d got=%b@%0d exp=%b@%0d", i, gval[i], gcyc[i], 4'b0001 << (i % 4), 4 * i);
      end
    end
    for (int i = 0; i < 4 && i < nr; i++) begin
      checks++;
      if (rid[i] !== 2'(i) || rk[i] !== exp_k[i]) begin
        failures++;
        $display("FAIL rr_result%0d got=%0d/%0d exp=%0d/%0d", i, rid[i], rk[i], i, exp_k[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int hs;
    hs = 0;
    do_reset();
    req_data[0*64 +: 64] = S_SINGLE;
    req_data[1*64 +: 64] = 64'h1234;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b1111;
    for (int cyc = 1; cyc < 13; cyc++) begin
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready_c%0d got=%b exp=0000", cyc, req_ready); end
      if (cyc >= 3) begin
        checks++;
        if (res_valid !== 1'b1 || res_klass !== 4'd1 || res_id !== 2'd0) begin
          failures++;
          $display("FAIL bp_hold_c%0d got=v%b k%0d id%0d exp=v1 k1 id0", cyc, res_valid, res_klass, res_id);
        end
      end
      tick();
    end
    res_ready = 1'b1;
    for (int cyc = 13; cyc < 17; cyc++) begin
      @(negedge clk);
      if (res_valid === 1'b1 && res_ready === 1'b1) hs++;
      if (cyc == 14) begin
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_next_grant got=%b exp=0010", req_ready); end
      end
      tick();
    end
    req_valid = 4'b0000;
    checks++; if (hs !== 1) begin failures++; $display("FAIL bp_one_result got=%0d exp=1", hs); end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    res_ready = 1'b1;
    req_valid = 4'b0100;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL wrap_first got=%b exp=0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    tick(); tick(); tick();
    req_valid = 4'b0011;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL wrap_grant0 got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0010;
    for (int cyc = 5; cyc < 9; cyc++) begin
      @(negedge clk);
      if (cyc == 7) begin
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd0) begin failures++; $display("FAIL wrap_res_id got=v%b id%0d exp=v1 id0", res_valid, res_id); end
      end
      if (cyc == 8) begin
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL wrap_grant1 got=%b exp=0010", req_ready); end
      end else begin
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL wrap_busy_c%0d got=%b exp=0000", cyc, req_ready); end
      end
      tick();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_in_settle();
    int seen;
    seen = 0;
    do_reset();
    res_ready = 1'b1;
    req_valid = 4'b0001; req_data[63:0] = S_SINGLE;
    tick();
    req_valid = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tnn_inp !== 64'h0) begin failures++; $display("FAIL rs_cleared got=busy%b inp=%h exp=busy0 inp=0", busy, tnn_inp); end
    if (res_valid === 1'b1) seen++;
    tick();
    rst = 1'b0;
    for (int cyc = 2; cyc < 6; cyc++) begin
      @(negedge clk);
      if (res_valid === 1'b1) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rs_no_result got=%0d exp=0", seen); end
    req_valid = 4'b1001;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rs_ptr_reset got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0000;
  endtask

  task automatic test_settle1();
    do_reset();
    res_ready1 = 1'b1;
    req_valid1 = 4'b0001; req_data1[63:0] = 64'h00000000000000a7;
    tick();
    req_valid1 = 4'b0000;
    @(negedge clk);
    checks++; if (res_valid1 !== 1'b0) begin failures++; $display("FAIL s1_c1_valid got=%b exp=0", res_valid1); end
    tick();
    @(negedge clk);
    checks++; if (res_valid1 !== 1'b1 || res_klass1 !== 4'd7) begin failures++; $display("FAIL s1_first got=v%b k%0d exp=v1 k7", res_valid1, res_klass1); end
    tick();
    req_valid1 = 4'b0001; req_data1[63:0] = 64'h0000000000000523;
    @(negedge clk);
    checks++; if (req_ready1 !== 4'b0001) begin failures++; $display("FAIL s1_grant got=%b exp=0001", req_ready1); end
    tick();
    req_valid1 = 4'b0000;
    @(negedge clk);
    checks++; if (res_valid1 !== 1'b0 || tnn_inp1 !== 64'h523) begin failures++; $display("FAIL s1_c1b got=v%b inp=%h exp=v0 inp=523", res_valid1, tnn_inp1); end
    tick();
    @(negedge clk);
    checks++; if (res_valid1 !== 1'b1 || res_klass1 !== 4'd3) begin failures++; $display("FAIL s1_new_klass got=v%b k%0d exp=v1 k3", res_valid1, res_klass1); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_reset_in_settle();
    test_settle1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
